// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B)
// writeback, registered write port, and a per-register pending scoreboard.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   RegWre,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [2**ADDR_W-1:0]   pending
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e              last_grant_r;
  grant_e              last_grant_s;
  logic                a_ready_s;
  logic                b_ready_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [DATA_W-1:0]   acc_data_s;
  logic                wr_en_s;
  logic [NREG-1:0]     pending_r;
  logic [NREG-1:0]     pending_s;
  logic                reg_wre_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   write_data_r;

  // Grant selection: lone requester wins, contention goes to the one not granted last.
  always_comb begin
    a_ready_s    = 1'b0;
    b_ready_s    = 1'b0;
    last_grant_s = last_grant_r;
    if (reset) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case ({a_valid, b_valid})
        2'b10: a_ready_s = 1'b1;
        2'b01: b_ready_s = 1'b1;
        2'b11: begin
          if (last_grant_r == GRANT_B) begin
            a_ready_s = 1'b1;
          end else begin
            b_ready_s = 1'b1;
          end
        end
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
    if (a_ready_s) begin
      last_grant_s = GRANT_A;
    end else if (b_ready_s) begin
      last_grant_s = GRANT_B;
    end else begin
      last_grant_s = last_grant_r;
    end
  end

  // Accepted-write mux; a write to register 0 completes the handshake but is dropped.
  always_comb begin
    acc_addr_s = {ADDR_W{1'b0}};
    acc_data_s = {DATA_W{1'b0}};
    if (a_ready_s) begin
      acc_addr_s = a_addr;
      acc_data_s = a_data;
    end else if (b_ready_s) begin
      acc_addr_s = b_addr;
      acc_data_s = b_data;
    end else begin
      acc_addr_s = {ADDR_W{1'b0}};
      acc_data_s = {DATA_W{1'b0}};
    end
    wr_en_s = (a_ready_s | b_ready_s) && (acc_addr_s != {ADDR_W{1'b0}});
  end

  // Scoreboard next state: clear on issued write, then set on reservation so set wins.
  always_comb begin
    pending_s = pending_r;
    if (wr_en_s) begin
      pending_s[acc_addr_s] = 1'b0;
    end else begin
      pending_s[acc_addr_s] = pending_r[acc_addr_s];
    end
    if (rsv_valid && (rsv_addr != {ADDR_W{1'b0}})) begin
      pending_s[rsv_addr] = 1'b1;
    end else begin
      pending_s[rsv_addr] = pending_s[rsv_addr];
    end
    pending_s[0] = 1'b0;
  end

  // State registers: grant pointer, scoreboard and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_B;
      pending_r    <= {NREG{1'b0}};
      reg_wre_r    <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else begin
      last_grant_r <= last_grant_s;
      pending_r    <= pending_s;
      reg_wre_r    <= wr_en_s;
      if (wr_en_s) begin
        wr_addr_r    <= acc_addr_s;
        write_data_r <= acc_data_s;
      end
    end
  end

  assign a_ready    = a_ready_s;
  assign b_ready    = b_ready_s;
  assign RegWre     = reg_wre_r;
  assign wr_addr    = wr_addr_r;
  assign write_data = write_data_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        RegWre;
  logic [4:0]  wr_addr;
  logic [31:0] write_data;
  logic [31:0] pending;

  int checks;
  int failures;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .RegWre(RegWre), .wr_addr(wr_addr), .write_data(write_data), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
    rsv_valid = 1'b0; rsv_addr = 5'd0;
    tick();
    tick();
    chk("rst_regwre", 32'(RegWre), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_pending", pending, 32'd0);

    // requests during reset are ignored
    a_valid = 1'b1; a_addr = 5'd5; b_valid = 1'b1; b_addr = 5'd4;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rst_rsv_ignored", pending, 32'd0);
    chk("rst_no_write", 32'(RegWre), 32'd0);
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;

    // single A write, addr 5
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000000A;
    #1;
    chk("a_only_a_ready", 32'(a_ready), 32'd1);
    chk("a_only_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("a5_regwre", 32'(RegWre), 32'd1);
    chk("a5_wr_addr", 32'(wr_addr), 32'd5);
    chk("a5_write_data", write_data, 32'h0000000A);
    tick();
    chk("a5_regwre_drop", 32'(RegWre), 32'd0);
    chk("a5_wr_addr_hold", 32'(wr_addr), 32'd5);
    chk("a5_data_hold", write_data, 32'h0000000A);

    // re-reset so contention starts from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // continuous contention: A addr 3, B addr 4 -> A,B,A,B
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    #1;
    chk("rr0_a_ready", 32'(a_ready), 32'd1);
    chk("rr0_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rr0_wr_addr", 32'(wr_addr), 32'd3);
    chk("rr0_regwre", 32'(RegWre), 32'd1);
    chk("rr1_a_ready", 32'(a_ready), 32'd0);
    chk("rr1_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("rr1_wr_addr", 32'(wr_addr), 32'd4);
    chk("rr1_write_data", write_data, 32'h44);
    chk("rr2_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("rr2_wr_addr", 32'(wr_addr), 32'd3);
    chk("rr3_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("rr3_wr_addr", 32'(wr_addr), 32'd4);
    chk("rr3_regwre", 32'(RegWre), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("idle_a_ready", 32'(a_ready), 32'd0);
    chk("idle_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rr_end_regwre", 32'(RegWre), 32'd0);

    // reserve r7, then B writes r7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk("rsv7_set", pending, 32'h00000080);
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
    #1;
    chk("b7_b_ready", 32'(b_ready), 32'd1);
    chk("b7_pending_before", pending, 32'h00000080);
    tick();
    b_valid = 1'b0;
    chk("b7_pending_clear", pending, 32'h0);
    chk("b7_regwre", 32'(RegWre), 32'd1);
    chk("b7_wr_addr", 32'(wr_addr), 32'd7);
    chk("b7_write_data", write_data, 32'h12345678);

    // same-cycle reserve and write to r9: set wins
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    #1;
    chk("a9_a_ready", 32'(a_ready), 32'd1);
    tick();
    rsv_valid = 1'b0; a_valid = 1'b0;
    chk("a9_pending_set_wins", pending, 32'h00000200);
    chk("a9_regwre", 32'(RegWre), 32'd1);
    chk("a9_wr_addr", 32'(wr_addr), 32'd9);

    // reserve r10 while B writes r9: both effects
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h909;
    tick();
    rsv_valid = 1'b0; b_valid = 1'b0;
    chk("diff_pending", pending, 32'h00000400);
    chk("diff_wr_addr", 32'(wr_addr), 32'd9);

    // write to non-pending r12, then re-reserve r10
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    tick();
    a_valid = 1'b0; rsv_valid = 1'b0;
    chk("nonpend_pending", pending, 32'h00000400);
    chk("nonpend_wr_addr", 32'(wr_addr), 32'd12);

    // write and reserve to r0 are both dropped
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1;
    chk("r0_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; rsv_valid = 1'b0;
    chk("r0_regwre", 32'(RegWre), 32'd0);
    chk("r0_pending", pending, 32'h00000400);

    // accept A r6, then reset the next cycle
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    tick();
    chk("a6_regwre", 32'(RegWre), 32'd1);
    reset = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #1;
    chk("rst2_a_ready", 32'(a_ready), 32'd0);
    chk("rst2_b_ready", 32'(b_ready), 32'd0);
    tick();
    rsv_valid = 1'b0;
    chk("rst2_regwre_drop", 32'(RegWre), 32'd0);
    chk("rst2_pending", pending, 32'h0);
    chk("rst2_wr_addr", 32'(wr_addr), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("post_rst_wr_addr", 32'(wr_addr), 32'd6);
    chk("post_rst_regwre", 32'(RegWre), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write data width.
REQ-002 Parameter: ADDR_W, 5, register address width; 2**ADDR_W registers, register 0 hardwired zero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 a_addr  input  ADDR_W  requester A destination register.
REQ-007 a_data  input  DATA_W  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-010 b_addr  input  ADDR_W  requester B destination register.
REQ-011 b_data  input  DATA_W  requester B write data.
REQ-012 b_ready  output  1  requester B write accepted this cycle.
REQ-013 rsv_valid  input  1  issue stage reserves a destination register.
REQ-014 rsv_addr  input  ADDR_W  register being reserved.
REQ-015 RegWre  output  1  register file write enable, registered.
REQ-016 wr_addr  output  ADDR_W  register file write address, registered.
REQ-017 write_data  output  DATA_W  register file write data, registered.
REQ-018 pending  output  2**ADDR_W  scoreboard; bit n = register n reserved, write not yet issued.

Function
REQ-019 Arbitration: at most one grant per cycle; a_ready/b_ready are combinational from valids and the last-grant pointer; never both high.
REQ-020 Only A valid: a_ready=1. Only B valid: b_ready=1. Neither: both 0.
REQ-021 Both valid: grant the requester not granted most recently (round-robin); last_grant pointer updates only on an actual grant.
REQ-022 Handshake: a write is accepted when valid&&ready in the same cycle; requester holds addr/data stable while valid&&!ready.
REQ-023 Latency: an accepted write appears on RegWre/wr_addr/write_data exactly 1 cycle after acceptance, for exactly 1 cycle.
REQ-024 No accept in a cycle: next cycle RegWre=0; wr_addr/write_data hold previous values.
REQ-025 Accepted write to address 0: handshake completes (ready=1), RegWre stays 0 next cycle; no write reaches register 0.
REQ-026 Scoreboard set: rsv_valid with rsv_addr!=0 sets pending[rsv_addr] on next edge; rsv_addr=0 ignored; pending[0] always 0.
REQ-027 Scoreboard clear: accepted write to address n!=0 clears pending[n] on the next edge (same edge RegWre is registered high).
REQ-028 Same-cycle reserve and accepted write to the same register: set wins; pending[n]=1 afterwards (new reservation outstanding).
REQ-029 Same-cycle reserve and write to different registers: both take effect.
REQ-030 Accepted write to a register with pending=0 is legal; bit remains 0.
REQ-031 Re-reserving an already pending register leaves bit 1 (no count).

Reset
REQ-032 reset=1 at an edge: RegWre=0, wr_addr=0, write_data=0, pending=0, last_grant=B (so A wins the first contention).
REQ-033 While reset=1: a_ready=0, b_ready=0; rsv_valid ignored; no write is accepted.
REQ-034 Reset asserted in the cycle after an accept: the registered write is dropped (RegWre=0 after that edge).

Verification
REQ-035 Reset, then A valid addr=5 data=0x0000000A one cycle -> a_ready=1 that cycle; next cycle RegWre=1, wr_addr=5, write_data=0xA; following cycle RegWre=0.
REQ-036 A and B both valid continuously (A addr=3, B addr=4) for 4 cycles -> grants A,B,A,B; RegWre sequence writes 3,4,3,4 one cycle delayed.
REQ-037 rsv_valid addr=7, then B writes addr=7 data=0x12345678 -> pending[7]=1 until the edge of the accept, 0 after; RegWre=1, wr_addr=7.
REQ-038 Same cycle: rsv_valid addr=9 and A accepted addr=9 -> pending[9]=1 afterwards; RegWre=1, wr_addr=9 next cycle.
REQ-039 A valid addr=0 data=0xFFFFFFFF -> a_ready=1; next cycle RegWre=0; rsv_valid addr=0 leaves pending=0.
REQ-040 Accept A addr=6, assert reset next cycle -> RegWre=0, pending=0, a_ready=b_ready=0 during reset; after release A and B both valid -> A granted first.
